rca_nibble_serial_adder: RTL and testbench



---
 rtl/rca_nibble_serial_adder.sv | 217 +++++++++++++++++++++
 tb/tb_rca_nibble_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_serial_adder.sv
// rca_nibble_serial_adder: digit-serial WIDTH-bit adder built around a single
// 4-bit ripple-carry adder (RCA). One nibble is added per clock, starting
// from the least significant nibble, with the carry kept in a register
// between nibbles.
// Handshakes: operands are accepted with in_valid/in_ready, and the result is
// returned with out_valid/out_ready.
// Optional build macro RCA_SERIAL_OVF_EN adds a registered signed-overflow
// output (ovf).

// 4-bit ripple-carry nibble adder
module RCA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c_s;

  // Ripple the carry through four full-adder bit slices
  always_comb begin
    c_s    = 5'd0;
    s      = 4'd0;
    c_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    cout = c_s[4];
  end
endmodule

module rca_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  // Counter only has to reach NIB-1, so it never wraps while in RUN
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  // Partial-result register holds the NIB-1 nibbles below the final one
  localparam int RW  = (WIDTH > 4) ? (WIDTH - 4) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  logic [3:0]       rca_s;
  logic             rca_cout;
  logic [RW-1:0]    res_shift_s;
  logic [WIDTH-1:0] sum_next_s;

`ifdef RCA_SERIAL_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  RCA u_rca (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (rca_s),
    .cout (rca_cout)
  );

  // New nibbles enter the partial result from the MSB end; the final nibble
  // goes straight into the sum without passing through the partial register
  generate
    if (WIDTH == 4) begin : g_w4
      assign res_shift_s = res_q;
      assign sum_next_s  = rca_s;
    end else if (WIDTH == 8) begin : g_w8
      assign res_shift_s = rca_s;
      assign sum_next_s  = {rca_s, res_q};
    end else begin : g_wn
      assign res_shift_s = {rca_s, res_q[RW-1:4]};
      assign sum_next_s  = {rca_s, res_q};
    end
  endgenerate

  // Next-state and datapath control for IDLE / RUN / DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
`ifdef RCA_SERIAL_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          res_d   = {RW{1'b0}};
          state_d = RUN;
`ifdef RCA_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = rca_cout;
        res_d   = res_shift_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          sum_d   = sum_next_s;
          cout_d  = rca_cout;
          valid_d = 1'b1;
          state_d = DONE;
`ifdef RCA_SERIAL_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (sum_next_s[WIDTH-1] != a_msb_q);
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      res_q   <= {RW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef RCA_SERIAL_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef RCA_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_rca_nibble_serial_adder.sv
// Directed, table-driven bench for rca_nibble_serial_adder (WIDTH=16 main
// instance plus a WIDTH=4 instance for the single-nibble case).
module tb_rca_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_busy;
  logic [3:0]  s_a, s_b, s_sum;
`ifdef RCA_SERIAL_OVF_EN
  logic        ovf, s_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int lat;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  rca_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef RCA_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout), .busy(busy)
  );

  rca_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum),
`ifdef RCA_SERIAL_OVF_EN
    .ovf(s_ovf),
`endif
    .cout(s_cout), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the main DUT idle; returns at the first
  // negedge where out_valid is seen (or after the bound expires)
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       output int l);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
    @(negedge clk);
    in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);
    l = 0;
    while (!out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = 4'h0; s_b = 4'h0; s_cin = 1'b0; s_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef RCA_SERIAL_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors with out_ready held high
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      chk($sformatf("v%0d_sum", i), {16'd0, sum}, {16'd0, vecs[i].esum});
      chk($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].ecout});
`ifdef RCA_SERIAL_OVF_EN
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].eovf});
`endif
      @(negedge clk);
      chk($sformatf("v%0d_valid_one_cycle", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_ready_after", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held for 5 cycles, in_valid ignored meanwhile
    out_ready = 1'b0;
    do_op(16'h00FF, 16'h0001, 1'b0, lat);
    chk("bp_latency", lat, 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum_hold", {16'd0, sum}, 32'h0000_0100);
      chk("bp_cout_hold", {31'd0, cout}, 32'd0);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
      @(negedge clk);
    end
    chk("bp_sum_end", {16'd0, sum}, 32'h0000_0100);
    in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_sum_after", {16'd0, sum}, 32'h0000_0100);

    // Reset two cycles into RUN
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    @(negedge clk);
    chk("mid_run_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_sum", {16'd0, sum}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_cout", {31'd0, cout}, 32'd0);
    do_op(16'h0F0F, 16'h00F1, 1'b1, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_sum", {16'd0, sum}, 32'h0000_1001);
    chk("post_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // WIDTH=4: single RUN cycle
    chk("w4_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_in_valid = 1'b1; s_a = 4'h9; s_b = 4'h8; s_cin = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_a = 4'h0; s_b = 4'h0; s_cin = 1'b0;
    chk("w4_busy", {31'd0, s_busy}, 32'd1);
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w4_latency", lat, 32'd1);
    chk("w4_sum", {28'd0, s_sum}, 32'h2);
    chk("w4_cout", {31'd0, s_cout}, 32'd1);
`ifdef RCA_SERIAL_OVF_EN
    chk("w4_ovf", {31'd0, s_ovf}, 32'd1);
`endif
    @(negedge clk);
    chk("w4_valid_drop", {31'd0, s_out_valid}, 32'd0);
    s_in_valid = 1'b1; s_a = 4'h5; s_b = 4'h6; s_cin = 1'b0;
    @(negedge clk);
    s_in_valid = 1'b0; s_a = 4'h0; s_b = 4'h0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w4b_latency", lat, 32'd1);
    chk("w4b_sum", {28'd0, s_sum}, 32'hB);
    chk("w4b_cout", {31'd0, s_cout}, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
